// File: rtl/signed_seq_multiplier.sv
// Sequential signed multiplier: sign-magnitude conversion, WIDTH-cycle shift-and-add,
// then a single conditional negation of the 2*WIDTH-bit product.
module signed_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   p_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  // The most-negative operand maps to 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH-1]) begin
      r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mag_a_q, mag_a_d;
  logic [WIDTH-1:0]     mag_b_q, mag_b_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   partial_s;

  assign partial_s = {{WIDTH{1'b0}}, mag_a_q} << cnt_q;

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d = state_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          mag_a_d = magnitude(a_i);
          mag_b_d = magnitude(b_i);
          neg_d   = a_i[WIDTH-1] ^ b_i[WIDTH-1];
          acc_d   = {(2*WIDTH){1'b0}};
          cnt_d   = {CW{1'b0}};
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (mag_b_q[0]) begin
          acc_d = acc_q + partial_s;
        end else begin
          acc_d = acc_q;
        end
        mag_b_d = mag_b_q >> 1;
        cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = SIGN;
        end else begin
          state_d = MUL;
        end
      end
      SIGN: begin
        if (neg_q) begin
          p_d = negate_2w(acc_q);
        end else begin
          p_d = acc_q;
        end
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == MUL) || (state_d == SIGN);
    done_d = (state_q == SIGN);
  end

  // State and output registers with synchronous reset; reset abandons any in-flight product.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mag_a_q <= {WIDTH{1'b0}};
      mag_b_q <= {WIDTH{1'b0}};
      neg_q   <= 1'b0;
      acc_q   <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CW{1'b0}};
      p_q     <= {(2*WIDTH){1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign p_o    = p_q;

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Bench for signed_seq_multiplier: fixed vector table, hand-written corner sequences,
// and random operands checked against signed integer multiplication.
module tb_signed_seq_multiplier;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] p_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[8];

  signed_seq_multiplier #(.WIDTH(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .p_o     (p_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int sa;
    int sb;
    int prod;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    prod = sa * sb;
    return prod[15:0];
  endfunction

  // Issue one operation, watch busy/done, check latency, busy length, product and pulse width.
  task automatic do_mult(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                         input string nm);
    int lat;
    int busy_n;
    @(negedge clk_i);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    a_i = 8'($urandom);
    b_i = 8'($urandom);
    lat = 0;
    busy_n = 0;
    while (!done_o && lat < 20) begin
      if (busy_o) busy_n++;
      @(posedge clk_i);
      #1;
      lat++;
    end
    chk({nm, "_done"}, {31'd0, done_o}, 32'd1);
    chk({nm, "_lat"}, lat, 32'd9);
    chk({nm, "_busy"}, busy_n, 32'd9);
    chk({nm, "_p"}, {16'd0, p_o}, {16'd0, exp});
    @(posedge clk_i);
    #1;
    chk({nm, "_pulse"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    int done_n;
    int lat;
    logic [7:0] ra;
    logic [7:0] rb;

    vecs[0] = '{8'h03, 8'h05, 16'h000F};
    vecs[1] = '{8'h80, 8'h80, 16'h4000};
    vecs[2] = '{8'h80, 8'h01, 16'hFF80};
    vecs[3] = '{8'h7F, 8'h81, 16'hC0FF};
    vecs[4] = '{8'hFE, 8'h00, 16'h0000};
    vecs[5] = '{8'h00, 8'h80, 16'h0000};
    vecs[6] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[7] = '{8'h80, 8'h7F, 16'hC080};

    rst_i = 1'b1;
    start_i = 1'b0;
    a_i = 8'd0;
    b_i = 8'd0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_p", {16'd0, p_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_mult(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Start pulse while busy must be ignored.
    @(negedge clk_i);
    a_i = 8'd7;
    b_i = 8'd6;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    a_i = 8'd1;
    b_i = 8'd1;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    done_n = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk_i);
      #1;
      if (done_o) begin
        done_n++;
        chk("ign_p", {16'd0, p_o}, 32'h002A);
      end
    end
    chk("ign_done_cnt", done_n, 32'd1);

    // Back-to-back: start held during the done cycle.
    @(negedge clk_i);
    a_i = 8'd3;
    b_i = 8'd4;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    chk("b2b_first_p", {16'd0, p_o}, 32'h000C);
    a_i = 8'hFF;
    b_i = 8'hFF;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    chk("b2b_busy", {31'd0, busy_o}, 32'd1);
    lat = 1;
    while (!done_o && lat < 20) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    chk("b2b_lat", lat, 32'd10);
    chk("b2b_p", {16'd0, p_o}, 32'h0001);
    repeat (2) @(posedge clk_i);

    // Reset during the 4th MUL cycle abandons the operation.
    @(negedge clk_i);
    a_i = 8'd7;
    b_i = 8'd6;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk("mrst_busy", {31'd0, busy_o}, 32'd0);
    chk("mrst_done", {31'd0, done_o}, 32'd0);
    chk("mrst_p", {16'd0, p_o}, 32'd0);
    done_n = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk_i);
      #1;
      if (done_o) done_n++;
    end
    chk("mrst_no_done", done_n, 32'd0);
    do_mult(8'd2, 8'hFD, 16'hFFFA, "post_rst");

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_mult(ra, rb, ref_mul(ra, rb), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/signed_seq_multiplier.md
# signed_seq_multiplier

Sequential signed multiplier for the ALU datapath, sitting directly downstream of the 8-bit two's-complement negation stage. It takes two's-complement operands, converts negative operands to magnitudes, multiplies the magnitudes by shift-and-add over WIDTH cycles, and negates the product when the operand signs differ. It trades area for latency next to the single-cycle combinational ALU ops.

## Interface
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE state.
- A  in  WIDTH  multiplicand, two's complement; captured on the accepting edge.
- B  in  WIDTH  multiplier, two's complement; captured on the accepting edge.
- busy  out  1  high while a multiplication is in progress (MUL, SIGN states).
- done  out  1  one-cycle pulse; P is valid and new.
- P  out  2*WIDTH  signed product; holds its value until the next done.

## Operation
- States: IDLE, MUL, SIGN, DONE.
- IDLE: busy=0, done=0. start=1 at an edge triggers acceptance:
  - latch magA = A[WIDTH-1] ? -A : A and magB likewise, as WIDTH-bit unsigned values;
  - latch neg = A[WIDTH-1] ^ B[WIDTH-1];
  - clear the accumulator (2*WIDTH bits) and the iteration counter;
  - go to MUL.
- MUL: each edge does the following:
  - if magB[0], acc += magA << count;
  - shift magB right by 1 and increment count;
  - after WIDTH iterations, go to SIGN.
- SIGN: at one edge, P <= neg ? -acc : acc (2*WIDTH-bit two's complement), done <= 1, go to DONE.
- DONE: lasts one cycle, with done=1 and busy=0.
  - If start=1 at the edge, accept the new operands exactly as from IDLE (back-to-back).
  - Otherwise return to IDLE.
- start while busy is ignored and not queued. A and B changes after acceptance have no effect.
- Width rules:
  - The magnitude of the most-negative value (-2^(WIDTH-1)) is 2^(WIDTH-1), held unsigned in WIDTH bits, so no extra bit is needed.
  - The largest magnitude product is 2^(2*WIDTH-2), which fits in 2*WIDTH signed bits. Overflow is impossible and no flag is provided.
- A product of zero is never negated to a nonzero value: -0 = 0 in two's complement.
- rst=1 at any edge, including mid-MUL:
  - state goes to IDLE; busy=0, done=0, P=0;
  - accumulator, counter and neg are cleared;
  - the in-flight operation is abandoned with no done pulse.

## Timing
- Accepting edge E0, with start=1 in IDLE/DONE.
- busy=1 in the cycles after E0 through E(WIDTH+1).
- MUL iterations occur at E1..E(WIDTH).
- SIGN writes P at E(WIDTH+1).
- done=1 in the single cycle after E(WIDTH+1). Latency is WIDTH+1 edges (9 for WIDTH=8).
- Back-to-back throughput is one result per WIDTH+2 cycles.
- Reset values: busy=0, done=0, P=0.
- P changes only at the SIGN edge or on reset.

## Test plan
- Reset, then A=3, B=5, start for 1 cycle -> busy high 9 cycles, then done pulse with P=0x000F.
- A=-128 (0x80), B=-128 -> P=0x4000 (16384). A=-128, B=1 -> P=0xFF80.
- A=127, B=-127 (0x81) -> P=0xC0FF (-16129). A=-2 (0xFE), B=0 -> P=0x0000 (no spurious negation).
- With A=7, B=6 accepted, pulse start with A=1, B=1 during busy -> ignored; result P=0x002A, exactly one done pulse.
- Hold start high with new operands (A=-1, B=-1) during the done cycle -> second op accepted immediately; the next done comes 10 cycles later with P=0x0001.
- Assert rst at the 4th MUL cycle -> next cycle busy=0, done=0, P=0; no done afterwards. A fresh A=2, B=-3 then gives P=0xFFFA.
